// File: rtl/plab5_mcore_sd_sched_pkg.sv
// Shared types and constants for the refill-network security-domain scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Contents: sd_state_e (ACTIVE/DRAIN/SWITCH encoding) and a parameter legality macro
// that a module expands in its own generate scope.
`ifndef PLAB5_MCORE_SD_SCHED_PKG_SV
`define PLAB5_MCORE_SD_SCHED_PKG_SV

// Elaboration-time guard: a slot needs at least one ACTIVE cycle, one DRAIN cycle
// and the single SWITCH cycle.
`define PLAB5_SD_SCHED_CHECK_PARAMS(slot_cycles, drain_cycles) \
  if (((drain_cycles) < 1) || ((slot_cycles) < ((drain_cycles) + 2))) begin : g_bad_params \
    $error("plab5_mcore_refill_sd_sched: need p_drain_cycles >= 1 and p_slot_cycles >= p_drain_cycles + 2"); \
  end

package plab5_mcore_sd_sched_pkg;

  localparam int STATE_NBITS = 2;

  typedef enum logic [STATE_NBITS-1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } sd_state_e;

endpackage

`endif

// File: rtl/plab5_mcore_popcount.sv
// Population count of a bit vector.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: i_bits (p_width) in, o_cnt ($clog2(p_width+1)) out = number of set bits.
module plab5_mcore_popcount #(
  parameter int p_width     = 4,
  parameter int p_cnt_nbits = $clog2(p_width + 1)
) (
  input  logic [p_width-1:0]     i_bits,
  output logic [p_cnt_nbits-1:0] o_cnt
);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < p_width; i++) begin
      o_cnt = o_cnt + p_cnt_nbits'(i_bits[i]);
    end
  end

endmodule

// File: rtl/plab5_mcore_refill_sd_sched.sv
// Time-slot owner of cur_sd for the refill ring; only the owning domain may inject.
// Latency: gating is combinational (zero cycles); schedule state is registered.
// Backpressure: slot timing is fixed and never stalls; non-owners just see req_rdy=0.
// Ports: req_val/req_sd/net_rdy/resp_fire in (per port); req_rdy/net_val out (gated);
// cur_sd, drain, slot_start, sched_err status out. reset is async active-low.
module plab5_mcore_refill_sd_sched
  import plab5_mcore_sd_sched_pkg::*;
#(
  parameter int p_num_ports      = 4,
  parameter int p_slot_cycles    = 64,
  parameter int p_drain_cycles   = 16,
  parameter int p_cnt_nbits      = $clog2(p_slot_cycles),
  parameter int p_inflight_nbits = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_num_ports-1:0] req_val,
  input  logic [p_num_ports-1:0] req_sd,
  output logic [p_num_ports-1:0] req_rdy,
  output logic [p_num_ports-1:0] net_val,
  input  logic [p_num_ports-1:0] net_rdy,
  input  logic [p_num_ports-1:0] resp_fire,
  output logic                   cur_sd,
  output logic                   drain,
  output logic                   slot_start,
  output logic                   sched_err
);

  `PLAB5_SD_SCHED_CHECK_PARAMS(p_slot_cycles, p_drain_cycles)

  localparam int lp_pc_nbits  = $clog2(p_num_ports + 1);
  localparam int lp_sum_nbits = p_inflight_nbits + lp_pc_nbits + 1;
  // Terminal counts: ACTIVE lasts (slot - drain - 1) cycles, DRAIN lasts drain cycles.
  localparam logic [p_cnt_nbits-1:0]  lp_act_tc   = p_cnt_nbits'(p_slot_cycles - p_drain_cycles - 2);
  localparam logic [p_cnt_nbits-1:0]  lp_drn_tc   = p_cnt_nbits'(p_drain_cycles - 1);
  localparam logic [lp_sum_nbits-1:0] lp_infl_max = lp_sum_nbits'((1 << p_inflight_nbits) - 1);

  sd_state_e                   r_state, w_state_nxt;
  logic [p_cnt_nbits-1:0]      r_phase, w_phase_nxt;
  logic                        r_cur_sd, w_cur_sd_nxt;
  logic [p_inflight_nbits-1:0] r_inflight, w_inflight_nxt;
  logic                        r_err, w_err_nxt;

  logic                        w_active;
  logic [p_num_ports-1:0]      w_ok;
  logic [p_num_ports-1:0]      w_inj;
  logic [lp_pc_nbits-1:0]      w_inj_cnt;
  logic [lp_pc_nbits-1:0]      w_rsp_cnt;
  logic [lp_sum_nbits-1:0]     w_sum;
  logic [lp_sum_nbits-1:0]     w_rsp_ext;
  logic [lp_sum_nbits-1:0]     w_diff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ACTIVE;
      r_phase    <= '0;
      r_cur_sd   <= 1'b0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_cur_sd   <= w_cur_sd_nxt;
      r_inflight <= w_inflight_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Schedule: purely time-driven, traffic never enters these equations.
  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase + p_cnt_nbits'(1);
    w_cur_sd_nxt = r_cur_sd;
    case (r_state)
      ACTIVE: begin
        if (r_phase == lp_act_tc) begin
          w_state_nxt = DRAIN;
          w_phase_nxt = '0;
        end
      end
      DRAIN: begin
        if (r_phase == lp_drn_tc) begin
          w_state_nxt = SWITCH;
          w_phase_nxt = '0;
        end
      end
      SWITCH: begin
        w_state_nxt  = ACTIVE;
        w_phase_nxt  = '0;
        w_cur_sd_nxt = ~r_cur_sd;
      end
      default: begin
        w_state_nxt = ACTIVE;
        w_phase_nxt = '0;
      end
    endcase
  end

  // The reset pin is folded in so the gated handshakes are quiet while reset is held,
  // even though the held state looks like ACTIVE/domain 0.
  assign w_active = reset & (r_state == ACTIVE);
  assign w_ok     = {p_num_ports{w_active}} & ~(req_sd ^ {p_num_ports{r_cur_sd}});
  assign net_val  = req_val & w_ok;
  assign req_rdy  = net_rdy & w_ok;
  assign w_inj    = req_val & net_rdy & w_ok;

  plab5_mcore_popcount #(.p_width(p_num_ports)) u_pc_inj (
    .i_bits (w_inj),
    .o_cnt  (w_inj_cnt)
  );

  plab5_mcore_popcount #(.p_width(p_num_ports)) u_pc_rsp (
    .i_bits (resp_fire),
    .o_cnt  (w_rsp_cnt)
  );

  // Add injections before subtracting responses so same-cycle traffic nets out
  // without a spurious transient underflow.
  assign w_sum     = lp_sum_nbits'(r_inflight) + lp_sum_nbits'(w_inj_cnt);
  assign w_rsp_ext = lp_sum_nbits'(w_rsp_cnt);
  assign w_diff    = w_sum - w_rsp_ext;

  always_comb begin
    w_inflight_nxt = r_inflight;
    w_err_nxt      = r_err;
    if ((r_state == SWITCH) && (r_inflight != '0)) begin
      w_err_nxt = 1'b1;
    end
    if (w_sum < w_rsp_ext) begin
      w_inflight_nxt = '0;
      w_err_nxt      = 1'b1;
    end else if (w_diff > lp_infl_max) begin
      w_inflight_nxt = '1;
      w_err_nxt      = 1'b1;
    end else begin
      w_inflight_nxt = p_inflight_nbits'(w_diff);
    end
  end

  assign cur_sd     = r_cur_sd;
  assign drain      = (r_state != ACTIVE);
  assign slot_start = w_active & (r_phase == '0);
  assign sched_err  = r_err;

endmodule

// File: tb/tb_plab5_mcore_refill_sd_sched.sv
module tb_plab5_mcore_refill_sd_sched;

  localparam int NP   = 4;
  localparam int SLOT = 64;
  localparam int DRN  = 16;
  localparam int ACT  = SLOT - DRN - 1;
  localparam int IMAX = 31;

  logic          clk = 1'b0;
  logic          reset;
  logic [NP-1:0] req_val, req_sd, net_rdy, resp_fire;
  logic [NP-1:0] req_rdy, net_val;
  logic          cur_sd, drain, slot_start, sched_err;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: time since reset release, outstanding refills, sticky error.
  int m_t    = 0;
  int m_infl = 0;
  bit m_err  = 1'b0;

  always #5 clk = ~clk;

  plab5_mcore_refill_sd_sched dut (
    .clk        (clk),
    .reset      (reset),
    .req_val    (req_val),
    .req_sd     (req_sd),
    .req_rdy    (req_rdy),
    .net_val    (net_val),
    .net_rdy    (net_rdy),
    .resp_fire  (resp_fire),
    .cur_sd     (cur_sd),
    .drain      (drain),
    .slot_start (slot_start),
    .sched_err  (sched_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", name, m_t, got, exp);
    end
  endtask

  function automatic int pc(input logic [NP-1:0] v);
    int n = 0;
    for (int i = 0; i < NP; i++) n += (v[i] === 1'b1) ? 1 : 0;
    return n;
  endfunction

  // Compare process: expected outputs derived from slot arithmetic on elapsed time.
  always @(negedge clk) begin : cmp
    int            pos;
    bit            sd;
    bit            act;
    logic [NP-1:0] ok;
    int            v;
    if (!reset) begin
      check("rst_cur_sd", cur_sd, 0);
      check("rst_drain", drain, 0);
      check("rst_slot_start", slot_start, 0);
      check("rst_sched_err", sched_err, 0);
      check("rst_net_val", net_val, 0);
      check("rst_req_rdy", req_rdy, 0);
      m_t    = 0;
      m_infl = 0;
      m_err  = 1'b0;
    end else begin
      pos = m_t % SLOT;
      sd  = ((m_t / SLOT) % 2) == 1;
      act = pos < ACT;
      for (int i = 0; i < NP; i++) ok[i] = act && (req_sd[i] == sd);
      check("cur_sd", cur_sd, sd);
      check("drain", drain, !act);
      check("slot_start", slot_start, pos == 0);
      check("sched_err", sched_err, m_err);
      check("net_val", net_val, req_val & ok);
      check("req_rdy", req_rdy, net_rdy & ok);
      if (pos == SLOT - 1 && m_infl != 0) m_err = 1'b1;
      v = m_infl + pc(req_val & ok & net_rdy) - pc(resp_fire);
      if (v > IMAX) begin
        v = IMAX;
        m_err = 1'b1;
      end else if (v < 0) begin
        v = 0;
        m_err = 1'b1;
      end
      m_infl = v;
      m_t++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req_val   = '0;
    req_sd    = '0;
    net_rdy   = '0;
    resp_fire = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clr();
    cyc();
    cyc();
    reset = 1'b1;
    #1;
  endtask

  // Random traffic; responses never exceed what the model says is outstanding,
  // and the drain window returns as much as possible.
  task automatic rand_inputs();
    int n;
    int lim;
    req_val   = NP'($urandom);
    req_sd    = NP'($urandom);
    net_rdy   = NP'($urandom);
    resp_fire = '0;
    lim = (m_infl > NP) ? NP : m_infl;
    if (lim > 0) begin
      if ((m_t % SLOT) >= ACT) n = lim;
      else if ($urandom_range(0, 9) < 7) n = $urandom_range(1, lim);
      else n = 0;
      resp_fire = NP'((1 << n) - 1);
    end else if ($urandom_range(0, 499) == 0) begin
      resp_fire = 4'b1000;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0d got=running exp=finished", m_t);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, f2, f0_bad, f2_bad, fd;
    reset = 1'b0;
    clr();

    // Schedule with no traffic.
    do_reset();
    for (int c = 0; c < 200; c++) begin
      case (m_t)
        0: begin
          check("lit_ss_0", slot_start, 1);
          check("lit_sd_0", cur_sd, 0);
          check("lit_drain_0", drain, 0);
        end
        1: check("lit_ss_1", slot_start, 0);
        46: check("lit_drain_46", drain, 0);
        47: check("lit_drain_47", drain, 1);
        63: begin
          check("lit_drain_63", drain, 1);
          check("lit_sd_63", cur_sd, 0);
        end
        64: begin
          check("lit_ss_64", slot_start, 1);
          check("lit_sd_64", cur_sd, 1);
          check("lit_drain_64", drain, 0);
        end
        128: begin
          check("lit_ss_128", slot_start, 1);
          check("lit_sd_128", cur_sd, 0);
        end
        192: check("lit_sd_192", cur_sd, 1);
        default: ;
      endcase
      cyc();
    end

    // Port 0 in domain 0 and port 2 in domain 1 both always requesting.
    do_reset();
    req_val = 4'b0101;
    net_rdy = 4'b0101;
    req_sd  = 4'b0100;
    #1;
    f0 = 0; f2 = 0; f0_bad = 0; f2_bad = 0; fd = 0;
    for (int c = 0; c < 128; c++) begin
      if (net_val[0] === 1'b1) begin
        f0++;
        if ((m_t / SLOT) % 2 == 1) f0_bad++;
      end
      if (net_val[2] === 1'b1) begin
        f2++;
        if ((m_t / SLOT) % 2 == 0) f2_bad++;
      end
      if ((m_t % SLOT) >= ACT && net_val !== 4'b0000) fd++;
      cyc();
    end
    check("lit_p0_fires", f0, 47);
    check("lit_p2_fires", f2, 47);
    check("lit_p0_odd_fires", f0_bad, 0);
    check("lit_p2_even_fires", f2_bad, 0);
    check("lit_drain_fires", fd, 0);

    // Balanced drain, then an unbalanced slot that must flag at SWITCH.
    do_reset();
    for (int c = 0; c <= 200; c++) begin
      if (m_t == 70)  check("lit_err_balanced", sched_err, 0);
      if (m_t == 127) check("lit_err_127", sched_err, 0);
      if (m_t == 128) check("lit_err_128", sched_err, 1);
      if (m_t == 200) check("lit_err_sticky", sched_err, 1);
      clr();
      if (m_t >= 5 && m_t <= 7) begin
        req_val[1] = 1'b1; net_rdy[1] = 1'b1; req_sd[1] = 1'b0;
      end
      if (m_t >= 50 && m_t <= 52) resp_fire[2] = 1'b1;
      if (m_t == 70 || m_t == 71) begin
        req_val[1] = 1'b1; net_rdy[1] = 1'b1; req_sd[1] = 1'b1;
      end
      if (m_t == 100) resp_fire[0] = 1'b1;
      cyc();
    end

    // Same-cycle netting and underflow.
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      if (m_t == 11) check("lit_err_net", sched_err, 0);
      if (m_t == 25) check("lit_err_25", sched_err, 0);
      if (m_t == 26) check("lit_err_underflow", sched_err, 1);
      clr();
      if (m_t == 3) begin
        req_val[0] = 1'b1; net_rdy[0] = 1'b1;
      end
      if (m_t == 10) begin
        req_val = 4'b0011; net_rdy = 4'b0011; resp_fire = 4'b0011;
      end
      if (m_t == 20 || m_t == 25) resp_fire = 4'b0001;
      cyc();
    end

    // Reset in the middle of an odd slot.
    do_reset();
    for (int c = 0; c < 94; c++) begin
      rand_inputs();
      cyc();
    end
    check("lit_sd_odd_94", cur_sd, 1);
    check("lit_drain_94", drain, 0);
    req_val = 4'hF; net_rdy = 4'hF; req_sd = 4'h0; resp_fire = '0;
    reset = 1'b0;
    #1;
    check("lit_abort_cur_sd", cur_sd, 0);
    check("lit_abort_drain", drain, 0);
    check("lit_abort_slot_start", slot_start, 0);
    check("lit_abort_net_val", net_val, 0);
    check("lit_abort_req_rdy", req_rdy, 0);
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    check("lit_rel_cur_sd", cur_sd, 0);
    check("lit_rel_slot_start", slot_start, 1);
    check("lit_rel_net_val", net_val, 4'hF);
    cyc();

    // Long random run with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      rand_inputs();
      reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      cyc();
    end
    reset = 1'b1;
    clr();
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
